// File: rtl/display_page_arbiter_pkg.sv
// Shared types and constants for the two-page display arbiter.
package display_page_arbiter_pkg;

  localparam int unsigned DEFAULT_CLK_RATE_HZ = 50_000_000;
  localparam int unsigned TICK_CYCLES         = DEFAULT_CLK_RATE_HZ / 1000;
  localparam int unsigned DIGITS_W            = 24;
  localparam int unsigned MASK_W              = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_0 = 2'd1,
    SHOW_1 = 2'd2,
    GAP    = 2'd3
  } state_e;

  // One page as presented to the display driver
  typedef struct packed {
    logic [DIGITS_W-1:0] digits;
    logic [MASK_W-1:0]   digit_en;
    logic [MASK_W-1:0]   dp_en;
  } page_t;

  // Clock cycles per millisecond for a given clock rate
  function automatic int unsigned tick_cycles(input int unsigned clk_rate_hz);
    return clk_rate_hz / 1000;
  endfunction

  // SHOW state for page k
  function automatic state_e show_state(input logic k);
    return k ? SHOW_1 : SHOW_0;
  endfunction

endpackage

// File: rtl/display_page_arbiter_if.sv
// Requester pages in, selected page and grant out.
interface display_page_arbiter_if;
  import display_page_arbiter_pkg::*;

  logic                req_0;
  logic                req_1;
  logic [DIGITS_W-1:0] data_0;
  logic [DIGITS_W-1:0] data_1;
  logic [MASK_W-1:0]   digit_enable_mask_0;
  logic [MASK_W-1:0]   digit_enable_mask_1;
  logic [MASK_W-1:0]   decimal_point_enable_mask_0;
  logic [MASK_W-1:0]   decimal_point_enable_mask_1;
  logic [1:0]          grant;
  logic [DIGITS_W-1:0] data;
  logic [MASK_W-1:0]   digit_enable_mask;
  logic [MASK_W-1:0]   decimal_point_enable_mask;

  modport master (
    output req_0, req_1, data_0, data_1,
           digit_enable_mask_0, digit_enable_mask_1,
           decimal_point_enable_mask_0, decimal_point_enable_mask_1,
    input  grant, data, digit_enable_mask, decimal_point_enable_mask
  );

  modport slave (
    input  req_0, req_1, data_0, data_1,
           digit_enable_mask_0, digit_enable_mask_1,
           decimal_point_enable_mask_0, decimal_point_enable_mask_1,
    output grant, data, digit_enable_mask, decimal_point_enable_mask
  );

endinterface

// File: rtl/ms_tick_generator.sv
// Millisecond prescaler: one-cycle tick every TICK_CYCLES_P cycles, restartable.
module ms_tick_generator
  import display_page_arbiter_pkg::*;
#(
  parameter int unsigned TICK_CYCLES_P = TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES_P > 1) ? $clog2(TICK_CYCLES_P) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last cycle of each millisecond window
  assign tick = (cnt_q == CW'(TICK_CYCLES_P - 1));

  // Restart wins over wrap so a new state always sees a full first millisecond
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_page_arbiter.sv
// Two-page display arbiter: dwell-based rotation with a blanking gap between pages.
module display_page_arbiter
  import display_page_arbiter_pkg::*;
#(
  parameter int unsigned CLK_RATE_HZ = DEFAULT_CLK_RATE_HZ,
  parameter int unsigned DWELL_MS    = 2000,
  parameter int unsigned BLANK_MS    = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  display_page_arbiter_if.slave bus
);

  localparam int unsigned TICKS  = tick_cycles(CLK_RATE_HZ);
  localparam int unsigned MS_MAX = (DWELL_MS > BLANK_MS) ? DWELL_MS : BLANK_MS;
  localparam int unsigned MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  localparam logic [MS_W-1:0] DWELL_LAST = MS_W'(DWELL_MS - 1);
  localparam logic [MS_W-1:0] BLANK_LAST = MS_W'(BLANK_MS - 1);

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            target_q, target_d;
  logic [MS_W-1:0] ms_q, ms_d;
  page_t           out_q, out_d;
  logic [1:0]      grant_q, grant_d;

  logic [1:0]      req;
  page_t           page0, page1;
  logic            tick;
  logic            ms_done;
  logic            state_change;

  assign req   = {bus.req_1, bus.req_0};
  assign page0 = {bus.data_0, bus.digit_enable_mask_0, bus.decimal_point_enable_mask_0};
  assign page1 = {bus.data_1, bus.digit_enable_mask_1, bus.decimal_point_enable_mask_1};

  // Prescaler restarts on every state entry (and on reset)
  ms_tick_generator #(
    .TICK_CYCLES_P (TICKS)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (reset | state_change),
    .tick    (tick)
  );

  // Last millisecond of the current state's period has just elapsed
  assign ms_done = tick && (ms_q == ((state_q == GAP) ? BLANK_LAST : DWELL_LAST));

  // Next state, tie pointer, gap target, ms count and next output image
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    target_d = target_q;
    out_d    = '0;
    grant_d  = 2'b00;

    case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
          state_d = show_state(rr_q);
        end else if (req[0]) begin
          state_d = SHOW_0;
        end else if (req[1]) begin
          state_d = SHOW_1;
        end
      end
      SHOW_0: begin
        // A drop takes precedence over a simultaneous dwell expiry
        if (!req[0] || (ms_done && req[1])) begin
          state_d  = GAP;
          target_d = 1'b1;
        end
      end
      SHOW_1: begin
        if (!req[1] || (ms_done && req[0])) begin
          state_d  = GAP;
          target_d = 1'b0;
        end
      end
      GAP: begin
        if (ms_done) begin
          if (req[target_q]) begin
            state_d = show_state(target_q);
          end else if (req[~target_q]) begin
            state_d = show_state(~target_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    state_change = (state_d != state_q);

    // Prefer the other page next time a tie is resolved
    if (state_change && (state_d == SHOW_0)) begin
      rr_d = 1'b1;
    end else if (state_change && (state_d == SHOW_1)) begin
      rr_d = 1'b0;
    end

    ms_d = ms_q;
    if (state_change) begin
      ms_d = '0;
    end else if (tick) begin
      ms_d = ms_done ? '0 : ms_q + MS_W'(1);
    end

    // Outputs follow the state being entered; only the granted page is ever loaded
    if (state_d == SHOW_0) begin
      out_d   = page0;
      grant_d = 2'b01;
    end else if (state_d == SHOW_1) begin
      out_d   = page1;
      grant_d = 2'b10;
    end
  end

  // State, pointer, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      target_q <= 1'b0;
      ms_q     <= '0;
      out_q    <= '0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      target_q <= target_d;
      ms_q     <= ms_d;
      out_q    <= out_d;
      grant_q  <= grant_d;
    end
  end

  assign bus.grant                     = grant_q;
  assign bus.data                      = out_q.digits;
  assign bus.digit_enable_mask         = out_q.digit_en;
  assign bus.decimal_point_enable_mask = out_q.dp_en;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Bench for display_page_arbiter: cycle-level reference model plus pinned literal expectations.
module tb_display_page_arbiter;

  localparam int unsigned CLK_HZ    = 10000;
  localparam int unsigned DWELL     = 3;
  localparam int unsigned BLANK     = 1;
  localparam int unsigned TPM       = CLK_HZ / 1000;
  localparam int          DWELL_CYC = int'(DWELL * TPM);
  localparam int          BLANK_CYC = int'(BLANK * TPM);

  logic clk = 1'b0;
  logic reset;

  display_page_arbiter_if bus ();

  display_page_arbiter #(
    .CLK_RATE_HZ (CLK_HZ),
    .DWELL_MS    (DWELL),
    .BLANK_MS    (BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Pinned literal expectation, checked on the negedge numbered pin_at
  int          pin_at = -1;
  string       pin_name;
  logic [1:0]  pin_grant;
  logic [23:0] pin_data;
  logic [5:0]  pin_den;
  logic [5:0]  pin_dpen;

  // Reference model: phase 0 idle, 1 showing m_page, 2 blank gap; m_cnt = cycles spent in phase
  int          m_phase = 0;
  int          m_page  = 0;
  int          m_tgt   = 0;
  int          m_pref  = 0;
  int          m_cnt   = 0;
  int          m_el, m_nph, m_np;
  logic [1:0]  m_r;
  logic [1:0]  e_grant = 2'b00;
  logic [23:0] e_data  = 24'h0;
  logic [5:0]  e_den   = 6'h0;
  logic [5:0]  e_dpen  = 6'h0;

  always @(posedge clk) begin
    m_r = {bus.req_1, bus.req_0};
    if (reset) begin
      m_phase = 0; m_page = 0; m_tgt = 0; m_pref = 0; m_cnt = 0;
    end else begin
      m_el  = m_cnt + 1;
      m_nph = m_phase;
      m_np  = m_page;
      case (m_phase)
        0: begin
          if (m_r == 2'b11) begin m_nph = 1; m_np = m_pref; end
          else if (m_r[0])  begin m_nph = 1; m_np = 0; end
          else if (m_r[1])  begin m_nph = 1; m_np = 1; end
        end
        1: begin
          if (!m_r[m_page] || ((m_el % DWELL_CYC) == 0 && m_r[1-m_page])) begin
            m_nph = 2; m_tgt = 1 - m_page;
          end
        end
        default: begin
          if (m_el == BLANK_CYC) begin
            if (m_r[m_tgt])        begin m_nph = 1; m_np = m_tgt; end
            else if (m_r[1-m_tgt]) begin m_nph = 1; m_np = 1 - m_tgt; end
            else                         m_nph = 0;
          end
        end
      endcase
      if (m_nph != m_phase) begin
        m_cnt = 0;
        if (m_nph == 1) m_pref = 1 - m_np;
      end else begin
        m_cnt = m_el;
      end
      m_phase = m_nph;
      m_page  = m_np;
    end
    if (m_phase == 1 && m_page == 0) begin
      e_grant = 2'b01; e_data = bus.data_0;
      e_den = bus.digit_enable_mask_0; e_dpen = bus.decimal_point_enable_mask_0;
    end else if (m_phase == 1) begin
      e_grant = 2'b10; e_data = bus.data_1;
      e_den = bus.digit_enable_mask_1; e_dpen = bus.decimal_point_enable_mask_1;
    end else begin
      e_grant = 2'b00; e_data = 24'h0; e_den = 6'h0; e_dpen = 6'h0;
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single compare process: model every cycle, plus the pinned literal when due
  always @(negedge clk) begin
    cyc++;
    chk("model grant", 24'(bus.grant), 24'(e_grant));
    chk("model data", bus.data, e_data);
    chk("model digit_en", 24'(bus.digit_enable_mask), 24'(e_den));
    chk("model dp_en", 24'(bus.decimal_point_enable_mask), 24'(e_dpen));
    if (cyc == pin_at) begin
      chk({pin_name, " grant"}, 24'(bus.grant), 24'(pin_grant));
      chk({pin_name, " data"}, bus.data, pin_data);
      chk({pin_name, " digit_en"}, 24'(bus.digit_enable_mask), 24'(pin_den));
      chk({pin_name, " dp_en"}, 24'(bus.decimal_point_enable_mask), 24'(pin_dpen));
    end
  end

  // Advance n rising edges, ending 1 time unit after the last
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pin the outputs produced by the edge that just passed
  task automatic expect_now(input string name, input logic [1:0] g, input logic [23:0] d,
                            input logic [5:0] de, input logic [5:0] dp);
    pin_name  = name;
    pin_grant = g;
    pin_data  = d;
    pin_den   = de;
    pin_dpen  = dp;
    pin_at    = cyc + 1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.data_0 = 24'h0; bus.data_1 = 24'h0;
    bus.digit_enable_mask_0 = 6'h0; bus.digit_enable_mask_1 = 6'h0;
    bus.decimal_point_enable_mask_0 = 6'h0; bus.decimal_point_enable_mask_1 = 6'h0;

    // Reset, then idle with no requests
    step(2);
    expect_now("reset", 2'b00, 24'h0, 6'h00, 6'h00);
    reset = 1'b0;
    step(100);
    expect_now("idle hold", 2'b00, 24'h0, 6'h00, 6'h00);

    // Single requester: one-edge latency, steady display, live data tracking
    bus.data_0 = 24'h123456;
    bus.digit_enable_mask_0 = 6'b111111;
    bus.decimal_point_enable_mask_0 = 6'b010101;
    bus.req_0 = 1'b1;
    step(1);
    expect_now("grant0 first edge", 2'b01, 24'h123456, 6'h3f, 6'h15);
    step(200);
    expect_now("grant0 steady", 2'b01, 24'h123456, 6'h3f, 6'h15);
    bus.data_0 = 24'habcdef;
    step(1);
    expect_now("grant0 live data", 2'b01, 24'habcdef, 6'h3f, 6'h15);
    bus.req_0 = 1'b0;
    step(1);
    expect_now("drop blanks", 2'b00, 24'h0, 6'h00, 6'h00);
    step(BLANK_CYC + 5);

    // Both requesters from reset: 30 cycles page 0, 10 blank, 30 page 1, repeat
    do_reset(2);
    bus.data_1 = 24'h654321;
    bus.digit_enable_mask_1 = 6'b001111;
    bus.decimal_point_enable_mask_1 = 6'b100000;
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    step(1);
    expect_now("tie picks 0", 2'b01, 24'habcdef, 6'h3f, 6'h15);
    step(29);
    expect_now("dwell last cycle", 2'b01, 24'habcdef, 6'h3f, 6'h15);
    step(1);
    expect_now("rotate blank", 2'b00, 24'h0, 6'h00, 6'h00);
    step(9);
    expect_now("blank last cycle", 2'b00, 24'h0, 6'h00, 6'h00);
    step(1);
    expect_now("rotate to 1", 2'b10, 24'h654321, 6'h0f, 6'h20);
    step(40);
    expect_now("rotate back to 0", 2'b01, 24'habcdef, 6'h3f, 6'h15);

    // Drop of the shown page mid-dwell
    do_reset(2);
    step(12);
    bus.req_0 = 1'b0;
    step(1);
    expect_now("drop at 12", 2'b00, 24'h0, 6'h00, 6'h00);
    step(9);
    expect_now("drop gap end", 2'b00, 24'h0, 6'h00, 6'h00);
    step(1);
    expect_now("after drop gap", 2'b10, 24'h654321, 6'h0f, 6'h20);

    // Reset aborts SHOW_1; page 0 preferred afterwards
    bus.req_0 = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    expect_now("reset abort", 2'b00, 24'h0, 6'h00, 6'h00);
    reset = 1'b0;
    step(1);
    expect_now("post reset tie", 2'b01, 24'habcdef, 6'h3f, 6'h15);

    // Both drop during the gap: idle, then the opposite page on reassert
    step(30);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    step(BLANK_CYC + 2);
    expect_now("idle after gap", 2'b00, 24'h0, 6'h00, 6'h00);
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    step(1);
    expect_now("opposite page", 2'b10, 24'h654321, 6'h0f, 6'h20);

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_page_arbiter.md
DISPLAY_PAGE_ARBITER -- requirements
Module: display_page_arbiter

Interface
REQ-001 Parameter CLK_RATE_HZ, default 50_000_000, system clock rate; SHALL be a multiple of 1000 and at least 1000.
REQ-002 Parameter DWELL_MS, default 2000, milliseconds a page is shown before rotating to a competing page; SHALL be at least 1.
REQ-003 Parameter BLANK_MS, default 100, milliseconds the display is blanked between pages; SHALL be at least 1.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_0, req_1  input  1 each  requester k wants the display; level, held for as long as wanted.
REQ-007 data_0, data_1  input  24 each  six 4-bit digits of page k, digit 5 in bits [23:20].
REQ-008 digit_enable_mask_0, digit_enable_mask_1  input  6 each  per-digit enable of page k.
REQ-009 decimal_point_enable_mask_0, decimal_point_enable_mask_1  input  6 each  per-digit decimal point of page k.
REQ-010 grant  output  2  one-hot; bit k is high while page k is shown; 2'b00 otherwise.
REQ-011 data  output  24  digits to the display driver.
REQ-012 digit_enable_mask  output  6  to the display driver.
REQ-013 decimal_point_enable_mask  output  6  to the display driver.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SHOW_0, SHOW_1 and GAP.
REQ-015 A one-bit round-robin pointer rr SHALL name the page preferred on a tie; it becomes 1-k on every entry to SHOW_k.
REQ-016 A millisecond prescaler SHALL restart on every state entry and issue a tick every CLK_RATE_HZ/1000 cycles; each state's ms counter counts these ticks from 0.
REQ-017 IDLE: if neither req is high, remain; if only req_k is high, go to SHOW_k; if both are high, go to SHOW_rr.
REQ-018 SHOW_k: if req_k is low, go to GAP with target 1-k.
REQ-019 SHOW_k: otherwise, when the dwell count reaches DWELL_MS and req_(1-k) is high, go to GAP with target 1-k.
REQ-020 SHOW_k: otherwise remain; the dwell count restarts at 0 when it reaches DWELL_MS, and stays in range without overflow.
REQ-021 A drop of req_k in the same cycle as dwell expiry SHALL be handled as a drop (REQ-018).
REQ-022 GAP SHALL last exactly BLANK_MS*CLK_RATE_HZ/1000 cycles whatever the req inputs do.
REQ-023 GAP exit: go to SHOW_target if req_target is high; else SHOW_(1-target) if that req is high; else IDLE.
REQ-024 Output registers SHALL load page k inputs on every edge whose next state is SHOW_k (1-cycle latency, live tracking).
REQ-025 Output registers SHALL load all zeros on every edge whose next state is IDLE or GAP.
REQ-026 grant SHALL be registered with the outputs, so grant and output data change on the same edge.
REQ-027 SHOW_k SHALL last exactly DWELL_MS*CLK_RATE_HZ/1000 cycles when it is pre-empted by rotation.
REQ-028 Data of the non-granted page SHALL never appear on the outputs.

Reset
REQ-029 While reset is sampled high, the next state SHALL be IDLE, rr SHALL be 0, prescaler and ms counters SHALL be 0, and grant, data and both masks SHALL be 0.
REQ-030 Reset during SHOW or GAP SHALL abort the page on that edge; no gap is inserted.

Structure
REQ-031 The state encoding and the constant TICK_CYCLES = CLK_RATE_HZ/1000 SHALL live in the shared display package.
REQ-032 The prescaler SHALL be a sub-module ms_tick_generator (ports clk, reset, restart, tick).

Verification (CLK_RATE_HZ=10000, DWELL_MS=3, BLANK_MS=1: 10 cycles/ms)
REQ-033 Reset for 2 cycles, req_0=req_1=0 -> grant=00, data=0, masks=0, and all stay 0 for 100 cycles.
REQ-034 req_0=1 with data_0=24'h123456, masks 6'b111111 and 6'b010101 -> the next edge gives grant=01 and those exact outputs; no change for 200 cycles; changing data_0 shows on the outputs one cycle later.
REQ-035 req_0=req_1=1 from IDLE -> page 0 for 30 cycles, then blank with grant=00 for 10 cycles, then page 1 for 30 cycles, repeating.
REQ-036 While SHOW_0 with req_1=1, drop req_0 at dwell cycle 12 -> blank for exactly 10 cycles, then grant=10.
REQ-037 Assert reset for 1 cycle during SHOW_1 -> outputs and grant are 0 at the next edge; with both reqs still high after release, page 0 is shown first.
REQ-038 Both reqs drop in GAP -> IDLE at gap end with outputs 0; both reassert -> the page opposite the last one shown.
